// File: rtl/robot_controller.sv
// Wall-following maze controller with barrier removal and step counting.
// Optional stuck detection: define ROBOT_CONTROLLER_STUCK_DET_EN.
module robot_controller #(
    parameter bit HAND          = 1'b0,
    parameter int STEP_W        = 16,
    parameter int REMOVE_CYCLES = 3,
    parameter int MAX_TURNS     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              head,
    input  logic              side,
    input  logic              under,
    input  logic              barrier,
    output logic              avancar,
    output logic              girar,
    output logic              sentido,
    output logic              remover,
    output logic              busy,
    output logic              done,
    output logic              stuck,
    output logic [STEP_W-1:0] step_count
);

    typedef enum logic [2:0] {
        STANDBY,
        INICIANDO,
        PROCURANDO_MURO,
        ACOMPANHANDO_MURO,
        ENTRANDO,
        REMOVENDO,
        CONCLUIDO
    } state_t;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic [7:0]        rm_cnt_q, rm_cnt_d;
    logic [STEP_W-1:0] step_d;
    logic              avancar_d, girar_d, sentido_d, remover_d;
    logic              busy_d, done_d;
    logic              settle, stuck_hit;
    logic              go_adv, go_turn, turn_dir, go_rm, go_done;

`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
    logic [3:0] turn_q, turn_d;
    logic       stuck_d;
    // The pulse that reached the limit is finishing its settle cycle.
    assign stuck_hit = girar && (turn_q == 4'(MAX_TURNS));
`else
    assign stuck_hit = 1'b0;
    assign stuck     = 1'b0;
`endif

    // Sensors are only trusted once the previous move has settled.
    assign settle = avancar | girar;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        rm_cnt_d  = rm_cnt_q;
        step_d    = step_count;
        avancar_d = 1'b0;
        girar_d   = 1'b0;
        sentido_d = 1'b0;
        remover_d = 1'b0;
        busy_d    = busy;
        done_d    = done;
        go_adv    = 1'b0;
        go_turn   = 1'b0;
        turn_dir  = 1'b0;
        go_rm     = 1'b0;
        go_done   = 1'b0;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
        turn_d    = turn_q;
        stuck_d   = stuck;
`endif
        unique case (state_q)
            STANDBY, CONCLUIDO: begin
                if (start) state_d = INICIANDO;
            end
            INICIANDO: begin
                busy_d  = 1'b1;
                done_d  = 1'b0;
                step_d  = '0;
                state_d = PROCURANDO_MURO;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
                turn_d  = '0;
                stuck_d = 1'b0;
`endif
            end
            PROCURANDO_MURO: begin
                if (!settle) begin
                    if (under) begin
                        go_done = 1'b1;
                    end else if (head && barrier) begin
                        go_rm = 1'b1;
                    end else if (head) begin
                        go_turn  = 1'b1;
                        turn_dir = HAND;
                        state_d  = ACOMPANHANDO_MURO;
                    end else if (side) begin
                        state_d = ACOMPANHANDO_MURO;
                    end else begin
                        go_adv = 1'b1;
                    end
                end
            end
            ACOMPANHANDO_MURO: begin
                if (!settle) begin
                    if (under) begin
                        go_done = 1'b1;
                    end else if (!side) begin
                        go_turn  = 1'b1;
                        turn_dir = ~HAND;
                        state_d  = ENTRANDO;
                    end else if (head && barrier) begin
                        go_rm = 1'b1;
                    end else if (head) begin
                        go_turn  = 1'b1;
                        turn_dir = HAND;
                    end else begin
                        go_adv = 1'b1;
                    end
                end
            end
            ENTRANDO: begin
                if (!settle) begin
                    if (under) begin
                        go_done = 1'b1;
                    end else begin
                        go_adv  = !head;
                        state_d = ACOMPANHANDO_MURO;
                    end
                end
            end
            REMOVENDO: begin
                if (rm_cnt_q == 8'd0) begin
                    state_d = ret_q;
                end else begin
                    remover_d = 1'b1;
                    rm_cnt_d  = rm_cnt_q - 8'd1;
                end
            end
            default: state_d = STANDBY;
        endcase

        if (stuck_hit) go_done = 1'b1;

        if (go_adv) begin
            avancar_d = 1'b1;
            if (step_count != '1) step_d = step_count + 1'b1;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
            turn_d = '0;
`endif
        end
        if (go_turn) begin
            girar_d   = 1'b1;
            sentido_d = turn_dir;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
            turn_d = turn_q + 4'd1;
`endif
        end
        if (go_rm) begin
            remover_d = 1'b1;
            rm_cnt_d  = 8'(REMOVE_CYCLES - 1);
            ret_d     = state_q;
            state_d   = REMOVENDO;
        end
        if (go_done) begin
            state_d = CONCLUIDO;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
            stuck_d = stuck_hit;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= STANDBY;
            ret_q      <= STANDBY;
            rm_cnt_q   <= '0;
            step_count <= '0;
            avancar    <= 1'b0;
            girar      <= 1'b0;
            sentido    <= 1'b0;
            remover    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
            turn_q     <= '0;
            stuck      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            rm_cnt_q   <= rm_cnt_d;
            step_count <= step_d;
            avancar    <= avancar_d;
            girar      <= girar_d;
            sentido    <= sentido_d;
            remover    <= remover_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
            turn_q     <= turn_d;
            stuck      <= stuck_d;
`endif
        end
    end

endmodule

// File: tb/tb_robot_controller.sv
// Bench for robot_controller: vector table, directed corner sequences
// and randomized sensor streams checked against an action-level model.
module tb_robot_controller;

    localparam int K_ADV  = 0;
    localparam int K_TURN = 1;
    localparam int K_REM  = 2;
    localparam int K_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic head = 1'b0, side = 1'b0;
    logic under = 1'b0, barrier = 1'b0;

    logic av0, gi0, se0, rm0, bz0, dn0, sk0;
    logic [15:0] step0;
    logic av1, gi1, se1, rm1, bz1, dn1, sk1;
    logic [1:0] step1;

    logic av, gi, se, rm, bz, dn, sk;
    int   stp;
    int   sel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    robot_controller u_dut0 (
        .clock(clk), .reset(reset), .start(start),
        .head(head), .side(side), .under(under),
        .barrier(barrier), .avancar(av0), .girar(gi0),
        .sentido(se0), .remover(rm0), .busy(bz0),
        .done(dn0), .stuck(sk0), .step_count(step0)
    );

    robot_controller #(
        .HAND(1'b1), .STEP_W(2), .REMOVE_CYCLES(2)
    ) u_dut1 (
        .clock(clk), .reset(reset), .start(start),
        .head(head), .side(side), .under(under),
        .barrier(barrier), .avancar(av1), .girar(gi1),
        .sentido(se1), .remover(rm1), .busy(bz1),
        .done(dn1), .stuck(sk1), .step_count(step1)
    );

    always_comb begin
        if (sel == 1) begin
            av = av1; gi = gi1; se = se1; rm = rm1;
            bz = bz1; dn = dn1; sk = sk1;
            stp = int'(step1);
        end else begin
            av = av0; gi = gi0; se = se0; rm = rm0;
            bz = bz0; dn = dn0; sk = sk0;
            stp = int'(step0);
        end
    end

    task automatic check(input string name, input int got,
                         input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_in(input int h, input int s,
                          input int u, input int b);
        head = (h != 0); side = (s != 0);
        under = (u != 0); barrier = (b != 0);
    endtask

    // Wait for the next visible action. val: step count for an
    // advance, sentido for a turn, strobe length for a removal,
    // stuck + 2*busy for done.
    task automatic get_action(output int kind, output int val);
        kind = -1;
        val = 0;
        for (int c = 0; c < 40 && kind < 0; c++) begin
            @(posedge clk);
            #1;
            check("excl", int'(av) + int'(gi) + int'(rm) > 1, 0);
            if (av) begin
                kind = K_ADV; val = stp;
            end else if (gi) begin
                kind = K_TURN; val = int'(se);
            end else if (rm) begin
                kind = K_REM; val = 1;
                for (int r = 0; r < 300; r++) begin
                    @(posedge clk);
                    #1;
                    if (!rm) break;
                    val++;
                    check("rm_quiet", int'(av | gi), 0);
                end
            end else if (dn) begin
                kind = K_DONE; val = int'(sk) + 2 * int'(bz);
            end
        end
    endtask

    task automatic expect_act(input string name, input int ek,
                              input int ev);
        int k, v;
        get_action(k, v);
        n_cmp++;
        if (k != ek || v != ev) begin
            n_bad++;
            $display("FAIL %s: got kind=%0d val=%0d want kind=%0d val=%0d",
                     name, k, v, ek, ev);
        end
    endtask

    // Spec rules per decision; mode 0 search, 1 follow, 2 entering.
    function automatic void resolve(input int h, input int s,
                                    input int u, input int b,
                                    input int hand, inout int mode,
                                    output int kind, output int val);
        kind = -1;
        val = 0;
        for (int k = 0; k < 4 && kind < 0; k++) begin
            if (u != 0) begin
                kind = K_DONE;
            end else if (mode == 0) begin
                if (h != 0 && b != 0) kind = K_REM;
                else if (h != 0) begin
                    kind = K_TURN; val = hand; mode = 1;
                end else if (s != 0) mode = 1;
                else kind = K_ADV;
            end else if (mode == 1) begin
                if (s == 0) begin
                    kind = K_TURN; val = 1 - hand; mode = 2;
                end else if (h != 0 && b != 0) kind = K_REM;
                else if (h != 0) begin
                    kind = K_TURN; val = hand;
                end else kind = K_ADV;
            end else begin
                mode = 1;
                if (h == 0) kind = K_ADV;
            end
        end
    endfunction

    typedef struct {
        int h, s, u, b;
        int kind, val;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int exp38[7];
        int k, v, g, act;
        int mode, steps, turns, pend, ek, ev, h, s, u, b;
        int hand, rlen, smax;

        tbl[0] = '{0, 0, 0, 0, K_ADV, 1};
        tbl[1] = '{1, 0, 0, 0, K_TURN, 0};
        tbl[2] = '{1, 0, 0, 1, K_REM, 3};
        tbl[3] = '{1, 0, 1, 0, K_DONE, 0};
        tbl[4] = '{0, 1, 0, 0, K_ADV, 1};
        tbl[5] = '{1, 1, 0, 0, K_TURN, 0};
        tbl[6] = '{1, 1, 1, 1, K_DONE, 0};
        tbl[7] = '{0, 0, 0, 1, K_ADV, 1};
        tbl[8] = '{1, 1, 0, 1, K_REM, 3};
        exp38 = '{0, 100, 111, 101, 112, 102, 113};

        // Reset state of both instances.
        do_reset();
        #1;
        check("rst0", int'({av0, gi0, se0, rm0, bz0, dn0, sk0, step0}), 0);
        check("rst1", int'({av1, gi1, se1, rm1, bz1, dn1, sk1, step1}), 0);

        // First decision from a fresh run, per table row.
        sel = 0;
        foreach (tbl[i]) begin
            do_reset();
            set_in(tbl[i].h, tbl[i].s, tbl[i].u, tbl[i].b);
            do_start();
            expect_act($sformatf("vec%0d", i), tbl[i].kind, tbl[i].val);
        end

        // Cycle-exact start and alternating advances.
        do_reset();
        set_in(0, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("run_c%0d", c),
                  int'(bz) * 100 + int'(av) * 10 + stp, exp38[c]);
        end

        // Opening turn direction and entry advance for both hands.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            do_reset();
            set_in(0, 1, 0, 0);
            do_start();
            expect_act("open_adv", K_ADV, 1);
            set_in(0, 0, 0, 0);
            expect_act("open_turn", K_TURN, 1 - d);
            expect_act("enter_adv", K_ADV, 2);
        end

        // Removal from wall following returns to wall following.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            do_reset();
            set_in(0, 1, 0, 0);
            do_start();
            expect_act("pre_rm", K_ADV, 1);
            set_in(1, 1, 0, 1);
            expect_act("rm_len", K_REM, 3 - d);
            set_in(0, 0, 0, 0);
            expect_act("rm_ret", K_TURN, 1 - d);
        end

        // Step counter saturation on the 2-bit instance.
        sel = 1;
        do_reset();
        set_in(0, 0, 0, 0);
        do_start();
        for (int n = 1; n <= 5; n++)
            expect_act($sformatf("sat%0d", n), K_ADV, n < 3 ? n : 3);

        // Boxed in: turning forever or stuck detection.
        sel = 0;
        do_reset();
        set_in(1, 1, 0, 0);
        do_start();
        g = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (gi) g++;
        end
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
        check("stuck_turns", g, 4);
        check("stuck_flags", int'({dn, sk, bz}), 3'b110);
`else
        check("spin_turns", int'(g >= 10), 1);
        check("spin_flags", int'({dn, sk, bz}), 3'b001);
`endif

        // Reset mid-removal with start held.
        do_reset();
        set_in(1, 0, 0, 1);
        do_start();
        g = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (rm) begin
                g = 1;
                break;
            end
        end
        check("rm_seen", g, 1);
        @(posedge clk);
        #1;
        check("rm_c2", int'(rm), 1);
        reset = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_mid%0d", c),
                  int'({rm, bz, dn, av, gi}) + stp, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        set_in(0, 0, 0, 0);
        act = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            act += int'(bz) + int'(av);
        end
        check("standby_idle", act, 0);

        // Randomized sensor streams against the action model.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            hand = d;
            rlen = d == 1 ? 2 : 3;
            smax = d == 1 ? 3 : 65535;
            do_reset();
            set_in(0, 0, 0, 0);
            do_start();
            mode = 0; steps = 0; turns = 0; pend = 0;
            repeat (150) begin
                h = int'($urandom_range(0, 2) == 0);
                s = int'($urandom_range(0, 1));
                u = int'($urandom_range(0, 19) == 0);
                b = int'($urandom_range(0, 3) == 0);
                set_in(h, s, u, b);
                if (pend != 0) begin
                    ek = K_DONE; ev = 1;
                end else begin
                    resolve(h, s, u, b, hand, mode, ek, ev);
                end
                if (ek == K_ADV) begin
                    if (steps < smax) steps++;
                    turns = 0;
                    ev = steps;
                end else if (ek == K_REM) begin
                    ev = rlen;
                end else if (ek == K_TURN) begin
                    turns++;
`ifdef ROBOT_CONTROLLER_STUCK_DET_EN
                    if (turns == 4) pend = 1;
`endif
                end else if (pend == 0) begin
                    ev = 0;
                end
                expect_act($sformatf("rnd%0d", d), ek, ev);
                if (ek == K_DONE) begin
                    do_start();
                    mode = 0; steps = 0; turns = 0; pend = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/robot_controller.md
ROBOT_CONTROLLER -- requirements
Module: robot_controller

Interface
REQ-001 The block SHALL have parameter HAND, default 0, meaning the followed wall side: 0 = left-hand rule, 1 = right-hand rule.
REQ-002 The block SHALL have parameter STEP_W, default 16, meaning the width of step_count.
REQ-003 The block SHALL have parameter REMOVE_CYCLES, default 3, range 1..255, meaning the number of cycles remover is held high.
REQ-004 The block SHALL have parameter MAX_TURNS, default 4, range 2..15, meaning the number of consecutive turns without an advance that declares stuck.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with the ports named as below.
REQ-006 Port clock, input, 1: sole clock; all logic is on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: begins a run when in STANDBY or CONCLUIDO.
REQ-009 Port head, input, 1: wall directly ahead.
REQ-010 Port side, input, 1: wall on the followed side (left if HAND=0, right if HAND=1).
REQ-011 Port under, input, 1: exit cell under the robot.
REQ-012 Port barrier, input, 1: the obstacle ahead is removable; valid only when head=1.
REQ-013 Port avancar, output, 1: one-cycle move-forward pulse.
REQ-014 Port girar, output, 1: one-cycle 90-degree turn pulse.
REQ-015 Port sentido, output, 1: turn direction, valid with girar: 0 = clockwise, 1 = counter-clockwise.
REQ-016 Port remover, output, 1: barrier-removal strobe.
REQ-017 Port busy, output, 1: a run is in progress.
REQ-018 Port done, output, 1: the run has ended.
REQ-019 Port stuck, output, 1: the run ended by stuck detection.
REQ-020 Port step_count, output, STEP_W: number of avancar pulses in the current run.

Function
REQ-021 All outputs SHALL be registered, and at most one of avancar, girar and remover SHALL be high in any cycle.
REQ-022 The state machine SHALL have the states STANDBY, INICIANDO, PROCURANDO_MURO, ACOMPANHANDO_MURO, ENTRANDO, REMOVENDO and CONCLUIDO.
REQ-023 The block SHALL sample sensors only in cycles in which avancar and girar are both low, so every pulse is followed by at least one non-pulse cycle (settle cycle).
REQ-024 In STANDBY, busy SHALL be 0 and start=1 SHALL cause a transition to INICIANDO.
REQ-025 INICIANDO SHALL last one cycle: it clears step_count, the turn counter, done and stuck, sets busy to 1, and then goes to PROCURANDO_MURO.
REQ-026 PROCURANDO_MURO SHALL apply these priorities: under=1 goes to CONCLUIDO; head=1 and barrier=1 goes to REMOVENDO; head=1 pulses girar with sentido=HAND (away from the side) and moves to ACOMPANHANDO_MURO; side=1 moves to ACOMPANHANDO_MURO; otherwise it pulses avancar and stays.
REQ-027 ACOMPANHANDO_MURO SHALL apply these priorities: under=1 goes to CONCLUIDO; side=0 pulses girar with sentido=~HAND and moves to ENTRANDO; head=1 and barrier=1 goes to REMOVENDO; head=1 pulses girar with sentido=HAND and stays; otherwise it pulses avancar and stays.
REQ-028 ENTRANDO SHALL, on its first sampling cycle, pulse avancar if head=0 and then return to ACOMPANHANDO_MURO; if head=1 it SHALL return to ACOMPANHANDO_MURO without a pulse.
REQ-029 REMOVENDO SHALL hold remover high for exactly REMOVE_CYCLES cycles and then return to the state it came from; no avancar or girar is issued during removal.
REQ-030 step_count SHALL increment on every avancar pulse and SHALL saturate at all-ones.
REQ-031 CONCLUIDO SHALL hold done=1 and busy=0, and SHALL hold step_count and stuck until start=1, which goes to INICIANDO.
REQ-032 start SHALL be ignored in every state other than STANDBY and CONCLUIDO.
REQ-033 If under=1 and any other condition are true together, under SHALL take priority.

Reset
REQ-034 On reset=1 at a clock edge, the state SHALL become STANDBY and all outputs and counters SHALL become 0 in the next cycle, including mid-removal (remover low the next cycle).
REQ-035 Reset SHALL take priority over start.

Configuration
REQ-036 With ROBOT_CONTROLLER_STUCK_DET_EN defined, a turn counter SHALL count girar pulses and clear on avancar; the girar pulse that reaches MAX_TURNS SHALL be followed by CONCLUIDO with stuck=1.
REQ-037 Without ROBOT_CONTROLLER_STUCK_DET_EN, the turn counter SHALL be absent, stuck SHALL be tied to 0, and the robot SHALL never end a run by turning.

Verification
REQ-038 Scenario: HAND=0, start, inputs head=0, side=0, under=0 -> INICIANDO, then avancar pulses on alternating cycles; step_count=3 after the third pulse.
REQ-039 Scenario: ACOMPANHANDO_MURO, side=0 -> girar with sentido=1, then after the settle cycle and with head=0, avancar; HAND=1 gives sentido=0.
REQ-040 Scenario: head=1, barrier=1, REMOVE_CYCLES=3 -> remover high for exactly 3 cycles, then the block returns to the originating state.
REQ-041 Scenario: stuck detection enabled, MAX_TURNS=4, head=1, side=1, barrier=0 constantly -> 4 girar pulses, then done=1 and stuck=1; with the macro undefined, girar repeats indefinitely and stuck=0.
REQ-042 Scenario: under=1 with head=1 -> CONCLUIDO with done=1 and no girar; STEP_W=2 forced past 5 advances -> step_count=3.
REQ-043 Scenario: reset asserted in cycle 2 of REMOVENDO -> remover=0, busy=0 and STANDBY the next cycle; start held during reset is ignored.
